exwb_stage: RTL and testbench

- Execute-to-writeback pipeline stage of the 8-register, 10-bit core.
- Produces the write-enable, destination and value signals that the forwarding logic and register file consume.
- Registers ALU results directly. For loads, it runs a req/ack data-memory read and returns the loaded value.
- Stalls the upstream EX/ID stages while a load is outstanding.

---
 rtl/core_pkg.sv | 14 +
 rtl/mem_timeout_ctr.sv | 35 +++
 rtl/exwb_stage.sv | 123 ++++++++++++
 tb/tb_exwb_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and widths used by the EX/WB stage, forwarding unit and register file.
package core_pkg;
    localparam int DATA_W = 10;
    localparam int REG_AW = 3;
    localparam int ADDR_W = 8;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } exwb_state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long a load waits for mem_ack; expired is high on count MEM_TIMEOUT-1.
// Saturates at the expiry value so a stuck enable cannot wrap the count.
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/exwb_stage.sv
// EX->WB stage: registers ALU results in 1 cycle; loads run a req/ack read (min 2 cycles) with timeout.
// stall_out holds EX/ID while a load is outstanding; the stalled EX instruction is taken on return to IDLE.
module exwb_stage #(
    parameter int DATA_W      = core_pkg::DATA_W,
    parameter int REG_AW      = core_pkg::REG_AW,
    parameter int ADDR_W      = core_pkg::ADDR_W,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_reg_wr,
    input  logic [REG_AW-1:0] ex_dest_reg,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              wb_wr,
    output logic [REG_AW-1:0] wb_dest_reg,
    output logic [DATA_W-1:0] wb_value
);
    import core_pkg::*;

    exwb_state_t       state_q, state_d;
    logic              wb_wr_q, wb_wr_d;
    logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_err_q, mem_err_d;
    logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
    logic              ld_wr_q, ld_wr_d;
    logic              expired;

    // Count is held at zero in IDLE, so it starts fresh for every load.
    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == IDLE),
        .en      ((state_q == REQ) && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        wb_wr_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_err_d  = 1'b0;
        ld_dest_d  = ld_dest_q;
        ld_wr_d    = ld_wr_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (ex_is_load) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = ex_result[ADDR_W-1:0];
                        ld_dest_d  = ex_dest_reg;
                        ld_wr_d    = ex_reg_wr;
                    end else begin
                        wb_wr_d    = ex_reg_wr;
                        wb_dest_d  = ex_dest_reg;
                        wb_value_d = ex_result;
                    end
                end
            end
            REQ: begin
                // Ack has priority over an expiry in the same cycle; flush is ignored here.
                if (mem_ack) begin
                    wb_wr_d    = ld_wr_q;
                    wb_dest_d  = ld_dest_q;
                    wb_value_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (expired) begin
                    mem_req_d  = 1'b0;
                    mem_err_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wb_wr_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_err_q  <= 1'b0;
            ld_dest_q  <= '0;
            ld_wr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_wr_q    <= wb_wr_d;
            wb_dest_q  <= wb_dest_d;
            wb_value_q <= wb_value_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_err_q  <= mem_err_d;
            ld_dest_q  <= ld_dest_d;
            ld_wr_q    <= ld_wr_d;
        end
    end

    assign stall_out   = (state_q == REQ);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_err     = mem_err_q;
    assign wb_wr       = wb_wr_q;
    assign wb_dest_reg = wb_dest_q;
    assign wb_value    = wb_value_q;
endmodule

// File: tb/tb_exwb_stage.sv
// Directed bench for exwb_stage: ALU vector table plus hand-written load/timeout/reset sequences.
module tb_exwb_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid, ex_is_load, ex_reg_wr, flush;
    logic [2:0] ex_dest_reg;
    logic [9:0] ex_result;
    logic       stall_out, mem_req, mem_ack, mem_err, wb_wr;
    logic [7:0] mem_addr;
    logic [9:0] mem_rdata, wb_value;
    logic [2:0] wb_dest_reg;

    int total = 0;
    int bad   = 0;

    exwb_stage #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_reg_wr   (ex_reg_wr),
        .ex_dest_reg (ex_dest_reg),
        .ex_result   (ex_result),
        .flush       (flush),
        .stall_out   (stall_out),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .wb_wr       (wb_wr),
        .wb_dest_reg (wb_dest_reg),
        .wb_value    (wb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       wr;
        logic       fl;
        logic [2:0] d;
        logic [9:0] r;
        logic       e_wr;
        logic [2:0] e_d;
        logic [9:0] e_val;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic wr, input logic fl,
                         input logic [2:0] d, input logic [9:0] r);
        ex_valid    = v;
        ex_is_load  = ld;
        ex_reg_wr   = wr;
        flush       = fl;
        ex_dest_reg = d;
        ex_result   = r;
    endtask

    task automatic chk_wb(input string nm, input logic e_wr, input logic [2:0] e_d, input logic [9:0] e_v);
        chk({nm, ".wb_wr"}, {31'd0, wb_wr}, {31'd0, e_wr});
        chk({nm, ".dest"}, {29'd0, wb_dest_reg}, {29'd0, e_d});
        chk({nm, ".value"}, {22'd0, wb_value}, {22'd0, e_v});
    endtask

    initial begin
        int reqs;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 3'd3, 10'h155, 1'b1, 3'd3, 10'h155};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd4, 10'h2AA, 1'b1, 3'd4, 10'h2AA};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd7, 10'h3FF, 1'b0, 3'd4, 10'h2AA};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 3'd2, 10'h111, 1'b0, 3'd4, 10'h2AA};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'd6, 10'h0F0, 1'b0, 3'd6, 10'h0F0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 3'd7, 10'h3FF, 1'b1, 3'd7, 10'h3FF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 3'd0, 10'h001, 1'b1, 3'd0, 10'h001};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
        mem_ack   = 1'b0;
        mem_rdata = 10'd0;
        rst_n     = 1'b0;
        #1;
        chk("rst.wb", {22'd0, wb_value, wb_dest_reg, wb_wr}, 32'd0);
        chk("rst.mem", {22'd0, mem_addr, mem_req, mem_err}, 32'd0);
        chk("rst.stall", {31'd0, stall_out}, 32'd0);
        tick();
        rst_n = 1'b1;

        // ALU pass-through, bubbles and flush.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, 1'b0, vecs[i].wr, vecs[i].fl, vecs[i].d, vecs[i].r);
            tick();
            chk_wb($sformatf("alu%0d", i), vecs[i].e_wr, vecs[i].e_d, vecs[i].e_val);
            chk($sformatf("alu%0d.stall", i), {31'd0, stall_out}, 32'd0);
        end

        // Load acked after 3 wait cycles; an ALU op waits behind the stall.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 10'h0A7);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 10'h0AB);
        chk("ld.req", {31'd0, mem_req}, 32'd1);
        chk("ld.addr", {24'd0, mem_addr}, 32'h0A7);
        chk("ld.wb_wr0", {31'd0, wb_wr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ld.stall%0d", i), {30'd0, stall_out, mem_req}, 32'd3);
            tick();
        end
        chk("ld.stall3", {31'd0, stall_out}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 10'h2C1;
        tick();
        mem_ack = 1'b0;
        chk_wb("ld.done", 1'b1, 3'd5, 10'h2C1);
        chk("ld.done.stall", {30'd0, stall_out, mem_req}, 32'd0);
        tick();
        chk_wb("ld.held_alu", 1'b1, 3'd1, 10'h0AB);

        // Flush during REQ does not kill the load.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 10'h012);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 10'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 10'h155;
        tick();
        mem_ack = 1'b0;
        flush   = 1'b0;
        chk_wb("fl_ld", 1'b1, 3'd6, 10'h155);
        chk("fl_ld.err", {31'd0, mem_err}, 32'd0);

        // Load without a register write still reads but never asserts wb_wr.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 10'h033);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
        chk("nowr.req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 10'h0C3;
        tick();
        mem_ack = 1'b0;
        chk_wb("nowr", 1'b0, 3'd2, 10'h0C3);

        // Timeout: mem_req high exactly 16 cycles, then one-cycle mem_err.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'h3C4);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
        chk("tmo.addr", {24'd0, mem_addr}, 32'h0C4);
        reqs = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            reqs++;
            chk("tmo.noerr", {31'd0, mem_err}, 32'd0);
            tick();
        end
        chk("tmo.req_cycles", reqs, 16);
        chk("tmo.err", {31'd0, mem_err}, 32'd1);
        chk("tmo.wb_wr", {31'd0, wb_wr}, 32'd0);
        chk("tmo.stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("tmo.err_pulse", {31'd0, mem_err}, 32'd0);

        // Ack arriving on the timeout cycle wins.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 10'h081);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("race.req", {30'd0, stall_out, mem_req}, 32'd3);
        mem_ack   = 1'b1;
        mem_rdata = 10'h24D;
        tick();
        mem_ack = 1'b0;
        chk_wb("race", 1'b1, 3'd7, 10'h24D);
        chk("race.err", {31'd0, mem_err}, 32'd0);
        tick();
        chk("race.err_after", {31'd0, mem_err}, 32'd0);

        // Reset mid-load, then a stray ack.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 10'h055);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstld.out", {29'd0, mem_req, stall_out, wb_wr}, 32'd0);
        #1;
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 10'h3FF;
        tick();
        chk("rstld.stray", {30'd0, wb_wr, mem_req}, 32'd0);
        mem_ack = 1'b0;
        tick();
        chk("rstld.quiet", {29'd0, wb_wr, mem_req, mem_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
